bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) producing the
//  four digits consumed by the multiplexed 7-seg display driver (s1..s4 digit inputs).
//  Sits between datapath debug/result registers and the display; the display-side
//  digit outputs are registered and held stable, so they never flicker mid-conversion.
// PARAMETERS
//  BIN_W   14   width of binary input; legal range 4..14 (10^4-1 = 9999 fits in 14 bits)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request conversion of bin_in; sampled only in IDLE
//  bin_in     in   BIN_W  unsigned binary value, sampled on the edge that accepts start
//  busy       out  1      high while a conversion is in progress (SHIFT/FINISH)
//  done       out  1      one-cycle pulse: new digits valid this cycle
//  overflow   out  1      last accepted bin_in > 9999
//  s1_data    out  4      ones digit      (rightmost display position)
//  s2_data    out  4      tens digit
//  s3_data    out  4      hundreds digit
//  s4_data    out  4      thousands digit
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, busy=0, done=0, overflow=0, s1..s4_data=0,
//    internal shift/BCD regs and bit counter cleared. Reset mid-conversion aborts it;
//    no done pulse for the aborted request.
//  - FSM: IDLE -> SHIFT -> FINISH -> IDLE.
//    IDLE:   start=1 at edge k: latch bin_in into shift reg, clear 16-bit BCD work reg,
//            counter=0, busy=1. If bin_in > 9999, go directly to FINISH with ovf flag.
//            Else -> SHIFT.
//    SHIFT:  each edge: every BCD nibble >= 5 gets +3 (all four nibbles corrected in
//            parallel, from pre-shift value), then {bcd,shift} shifted left by 1.
//            Exactly BIN_W iterations (edges k+1..k+BIN_W), then -> FINISH.
//    FINISH: one edge: copy BCD nibbles to s1..s4_data (or 4'hF on all four if ovf),
//            overflow <= ovf flag, done <= 1, busy <= 0, -> IDLE.
//  - Latency: normal path done=1 in the cycle after edge k+BIN_W+1 (BIN_W+1 edges after
//    accept; 15 for BIN_W=14). Overflow path: done after edge k+2 (2 edges).
//  - done is high for exactly one cycle, coinciding with the first IDLE cycle; a start in
//    that same cycle is accepted (back-to-back conversions, period BIN_W+2 cycles).
//  - start while busy=1 is ignored, not queued; bin_in changes while busy have no effect.
//  - s1..s4_data and overflow change only on the FINISH edge; hold previous result during
//    conversion and indefinitely in IDLE.
//  - Nibble correction: 4-bit add, result <= 12 by construction; no carry out of nibble.
//  - For BIN_W < 14 the overflow comparison is constant-false; unused upper digits are 0.
// TESTING
//  1. rst_n=0 then release, no start -> busy=0, done=0, overflow=0, all digits 0.
//  2. start with bin_in=1234 -> done 15 edges later; s4..s1 = 1,2,3,4; overflow=0;
//     busy high exactly 15 cycles.
//  3. bin_in=0, then 9999, then 5 back-to-back (start on each done cycle) -> digits
//     0000, 9999, 0005; each done one cycle wide, period 16 cycles.
//  4. bin_in=10000 -> done after 2 edges, all digits 4'hF, overflow=1; next start with
//     42 -> digits 0042, overflow=0.
//  5. start 1234, pulse start with 5678 at cycle 5 of conversion -> ignored; result 1234;
//     digits from prior result unchanged until done.
//  6. start 8765, assert rst_n=0 at cycle 7 -> all outputs 0 immediately (async); after
//     release no done pulse; fresh start 321 -> digits 0321.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter using shift-add-3, one
//               input bit per clock. Produces the four digits consumed by the
//               multiplexed 7-segment display driver. Digit and overflow
//               outputs are registered and change only when a conversion
//               completes, so the display never shows intermediate values.
//
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               start     - conversion request, sampled only when idle
//               bin_in    - unsigned binary value, captured with start
//               busy      - conversion in progress
//               done      - one-cycle pulse, new digits valid
//               overflow  - last accepted value exceeded 9999
//               s1_data   - ones digit
//               s2_data   - tens digit
//               s3_data   - hundreds digit
//               s4_data   - thousands digit
//
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       s1_data,
    output logic [3:0]       s2_data,
    output logic [3:0]       s3_data,
    output logic [3:0]       s4_data
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SHIFT  = 2'd1;
    localparam logic [1:0] c_S_FINISH = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [BIN_W-1:0] r_shift;
    logic [15:0]      r_bcd;
    logic [15:0]      w_bcd_adj;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_ovf_wait;
    logic             w_in_ovf;
    logic             w_publish;
    logic             r_done;
    logic             r_overflow;
    logic [15:0]      r_digits;

    // ------------------------------------------------------------------------
    // Out-of-range detection. Only a 14-bit input can exceed four digits;
    // narrower inputs never overflow.
    // ------------------------------------------------------------------------
    generate
        if (BIN_W >= 14) begin : g_ovf_cmp
            assign w_in_ovf = (32'(bin_in) > 32'd9999);
        end else begin : g_ovf_none
            assign w_in_ovf = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Add-3 correction on every nibble, all taken from the pre-shift value.
    // A nibble is at most 9 before correction, so the result fits in 4 bits.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? (r_bcd[gi*4 +: 4] + 4'd3)
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    // An out-of-range request spends one extra cycle in FINISH so it
    // completes two edges after acceptance.
    assign w_publish = !r_ovf || r_ovf_wait;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_next_state = w_in_ovf ? c_S_FINISH : c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
                    w_next_state = c_S_FINISH;
                end
            end
            c_S_FINISH: begin
                if (w_publish) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_ovf_wait <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_digits   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_shift    <= bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf      <= w_in_ovf;
                        r_ovf_wait <= 1'b0;
                    end
                end
                c_S_SHIFT: begin
                    r_bcd   <= (w_bcd_adj << 1) | 16'(r_shift[BIN_W-1]);
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                end
                c_S_FINISH: begin
                    if (w_publish) begin
                        r_digits   <= r_ovf ? 16'hFFFF : r_bcd;
                        r_overflow <= r_ovf;
                        r_done     <= 1'b1;
                    end else begin
                        r_ovf_wait <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (r_state != c_S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign s1_data  = r_digits[3:0];
    assign s2_data  = r_digits[7:4];
    assign s3_data  = r_digits[11:8];
    assign s4_data  = r_digits[15:12];

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. The driver issues
//               requests and pushes the expected digits, overflow flag and
//               completion cycle into a queue; a monitor pops and compares on
//               every done pulse and checks that outputs hold in between.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       s1_data;
    logic [3:0]       s2_data;
    logic [3:0]       s3_data;
    logic [3:0]       s4_data;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .s1_data  (s1_data),
        .s2_data  (s2_data),
        .s3_data  (s3_data),
        .s4_data  (s4_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
        int          due;
        int          busy_len;
    } exp_t;

    exp_t        q[$];
    logic [15:0] last_digits = '0;
    logic        last_ovf = 1'b0;
    int          busy_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decimal digits by division, latency from the
    // documented timing (2 edges for out-of-range, BIN_W+1 otherwise).
    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.digits   = 16'hFFFF;
            e.ovf      = 1'b1;
            e.busy_len = 2;
        end else begin
            e.digits   = {4'((v / 1000) % 10), 4'((v / 100) % 10),
                          4'((v / 10) % 10), 4'(v % 10)};
            e.ovf      = 1'b0;
            e.busy_len = BIN_W + 1;
        end
        e.due = 0;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("digits", 32'({s4_data, s3_data, s2_data, s1_data}), 32'(e.digits));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    chk("done_cycle", 32'(cyc), 32'(e.due));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_len));
                    last_digits = e.digits;
                    last_ovf    = e.ovf;
                end
                busy_cnt = 0;
            end else begin
                chk("hold_digits", 32'({s4_data, s3_data, s2_data, s1_data}), 32'(last_digits));
                chk("hold_overflow", 32'(overflow), 32'(last_ovf));
            end
        end
    end

    // Called at a negedge while the DUT is idle; the request is accepted on
    // the following posedge.
    task automatic issue(input int v);
        exp_t e;
        e     = model(v);
        e.due = cyc + 1 + e.busy_len;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !busy) return;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_digits"}, 32'({s4_data, s3_data, s2_data, s1_data}), 32'd0);
    endtask

    initial begin
        int v;
        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("post_reset");

        // Single conversion
        issue(1234);
        drain();

        // Back-to-back, start in each done cycle
        issue(0);
        wait_done();
        issue(9999);
        wait_done();
        issue(5);
        drain();

        // Out-of-range then recovery
        issue(10000);
        drain();
        issue(42);
        drain();

        // Start while busy is ignored
        issue(1234);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = BIN_W'(5678);
        @(negedge clk);
        start  = 1'b0;
        drain();

        // Asynchronous reset mid-conversion aborts the request
        issue(8765);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        q.delete();
        last_digits = '0;
        last_ovf    = 1'b0;
        busy_cnt    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(321);
        drain();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                wait_done();
            end else begin
                drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue(v);
            if (v <= 9999 && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                if (busy) begin
                    start  = 1'b1;
                    bin_in = BIN_W'($urandom);
                    @(negedge clk);
                    start  = 1'b0;
                end
            end
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
